// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: ID-stage operand info in, forwarding/stall controls out.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_wr;
    logic       id_mem_reg;
    logic       ex_branch_taken;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
    logic [1:0] ex_is_stall;
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_flush;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_reg_wr, id_mem_reg, ex_branch_taken,
        output fwd_rs1, fwd_rs2, ex_is_stall, pc_hold, ifid_hold, ifid_flush
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_reg_wr, id_mem_reg, ex_branch_taken,
        input  fwd_rs1, fwd_rs2, ex_is_stall, pc_hold, ifid_hold, ifid_flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Data-hazard forwarding, load-use stall and branch flush control for a 5-stage pipeline.
// Define HAZ_MEM_FWD_EN to enable MEM/WB forwarding; otherwise MEM-stage hazards stall.
//
// state   | meaning
// RUN     | normal issue, shadows track EX/MEM
// LDSTALL | bubble in EX, held ID instruction re-evaluated
// FLUSH   | bubble in EX after a taken branch, branches ignored
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2} state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    state_t     state_q, state_d;
    slot_t      exs_q, exs_d, mems_q, mems_d;
    logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d, stall_q, stall_d;

    logic exs_m1, exs_m2, mems_m1, mems_m2;
    logic need1, need2, hazard, branch, hold;

    assign exs_m1  = exs_q.wr  && (exs_q.rd  != 5'd0) && (exs_q.rd  == hz.id_rs1) && hz.id_use_rs1;
    assign exs_m2  = exs_q.wr  && (exs_q.rd  != 5'd0) && (exs_q.rd  == hz.id_rs2) && hz.id_use_rs2;
    assign mems_m1 = mems_q.wr && (mems_q.rd != 5'd0) && (mems_q.rd == hz.id_rs1) && hz.id_use_rs1;
    assign mems_m2 = mems_q.wr && (mems_q.rd != 5'd0) && (mems_q.rd == hz.id_rs2) && hz.id_use_rs2;

`ifdef HAZ_MEM_FWD_EN
    assign need1 = exs_m1 && exs_q.ld;
    assign need2 = exs_m2 && exs_q.ld;
`else
    // Without a MEM/WB path, only a non-load EX match can be forwarded.
    assign need1 = (exs_m1 && exs_q.ld) || (!exs_m1 && mems_m1);
    assign need2 = (exs_m2 && exs_q.ld) || (!exs_m2 && mems_m2);
`endif

    assign hazard = hz.id_valid && (need1 || need2);
    assign branch = hz.ex_branch_taken && (state_q != FLUSH);
    assign hold   = hazard && !branch && (state_q != FLUSH);

    always_comb begin
        state_d = state_q;
        exs_d   = '{rd: hz.id_rd, wr: hz.id_reg_wr & hz.id_valid, ld: hz.id_mem_reg & hz.id_valid};
        mems_d  = exs_q;
        stall_d = 2'b00;
`ifdef HAZ_MEM_FWD_EN
        fwd1_d  = (exs_m1 && !exs_q.ld) ? 2'b10 : (mems_m1 ? 2'b01 : 2'b00);
        fwd2_d  = (exs_m2 && !exs_q.ld) ? 2'b10 : (mems_m2 ? 2'b01 : 2'b00);
`else
        fwd1_d  = (exs_m1 && !exs_q.ld) ? 2'b10 : 2'b00;
        fwd2_d  = (exs_m2 && !exs_q.ld) ? 2'b10 : 2'b00;
`endif
        case (state_q)
            RUN, LDSTALL: begin
                if (branch) begin
                    state_d = FLUSH;
                end else if (hold) begin
                    state_d = LDSTALL;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
        if (branch || hold) begin
            exs_d   = '0;
            fwd1_d  = 2'b00;
            fwd2_d  = 2'b00;
            stall_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            exs_q   <= '0;
            mems_q  <= '0;
            fwd1_q  <= 2'b00;
            fwd2_q  <= 2'b00;
            stall_q <= 2'b00;
        end else begin
            state_q <= state_d;
            exs_q   <= exs_d;
            mems_q  <= mems_d;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
            stall_q <= stall_d;
        end
    end

    // Combinational controls are gated so reset silences them even with live inputs.
    assign hz.pc_hold     = rst_n & hold;
    assign hz.ifid_hold   = rst_n & hold;
    assign hz.ifid_flush  = rst_n & branch;
    assign hz.fwd_rs1     = fwd1_q;
    assign hz.fwd_rs2     = fwd2_q;
    assign hz.ex_is_stall = stall_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expectations follow HAZ_MEM_FWD_EN when defined.
module tb_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic br);
        hz.id_valid        = v;
        hz.id_rs1          = rs1;
        hz.id_use_rs1      = u1;
        hz.id_rs2          = rs2;
        hz.id_use_rs2      = u2;
        hz.id_rd           = rd;
        hz.id_reg_wr       = wr;
        hz.id_mem_reg      = ld;
        hz.ex_branch_taken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        idle();
        tick();
        tick();
    endtask

    task automatic comb(input string tag, input logic ph, input logic ih, input logic fl);
        #1;
        chk({tag, ".pc_hold"},    {1'b0, hz.pc_hold},    {1'b0, ph});
        chk({tag, ".ifid_hold"},  {1'b0, hz.ifid_hold},  {1'b0, ih});
        chk({tag, ".ifid_flush"}, {1'b0, hz.ifid_flush}, {1'b0, fl});
    endtask

    task automatic regs(input string tag, input logic [1:0] f1, input logic [1:0] f2, input logic [1:0] st);
        chk({tag, ".fwd_rs1"},     hz.fwd_rs1,     f1);
        chk({tag, ".fwd_rs2"},     hz.fwd_rs2,     f2);
        chk({tag, ".ex_is_stall"}, hz.ex_is_stall, st);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        comb("reset_br_high", 1'b0, 1'b0, 1'b0);
        regs("reset", 2'b00, 2'b00, 2'b00);
        idle();
        #2 rst_n = 1'b1;
        tick();

        // back-to-back ALU dependency: add x5,x1,x2 ; add x6,x5,x1
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        comb("ex_fwd.prod", 1'b0, 1'b0, 1'b0);
        tick();
        regs("ex_fwd.prod", 2'b00, 2'b00, 2'b00);
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        comb("ex_fwd.cons", 1'b0, 1'b0, 1'b0);
        tick();
        regs("ex_fwd.cons", 2'b10, 2'b00, 2'b00);

        // add x5 ; nop ; sub x7,x2,x5
        clear();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
`ifdef HAZ_MEM_FWD_EN
        comb("mem_fwd.cons", 1'b0, 1'b0, 1'b0);
        tick();
        regs("mem_fwd.cons", 2'b00, 2'b01, 2'b00);
`else
        comb("mem_stall.cons", 1'b1, 1'b1, 1'b0);
        tick();
        regs("mem_stall.bubble", 2'b00, 2'b00, 2'b10);
        comb("mem_stall.held", 1'b0, 1'b0, 1'b0);
        tick();
        regs("mem_stall.issue", 2'b00, 2'b00, 2'b00);
`endif

        // lw x8 ; add x9,x8,x8
        clear();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        comb("ldu.detect", 1'b1, 1'b1, 1'b0);
        tick();
        regs("ldu.bubble", 2'b00, 2'b00, 2'b10);
`ifdef HAZ_MEM_FWD_EN
        comb("ldu.held", 1'b0, 1'b0, 1'b0);
        tick();
        regs("ldu.issue", 2'b01, 2'b01, 2'b00);
`else
        comb("ldu.held1", 1'b1, 1'b1, 1'b0);
        tick();
        regs("ldu.bubble2", 2'b00, 2'b00, 2'b10);
        comb("ldu.held2", 1'b0, 1'b0, 1'b0);
        tick();
        regs("ldu.issue", 2'b00, 2'b00, 2'b00);
`endif

        // x0 as destination (ALU and load) never forwards or stalls
        clear();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        comb("x0.alu_reader", 1'b0, 1'b0, 1'b0);
        tick();
        regs("x0.alu_reader", 2'b00, 2'b00, 2'b00);
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        comb("x0.load_reader", 1'b0, 1'b0, 1'b0);
        tick();
        regs("x0.load_reader", 2'b00, 2'b00, 2'b00);

        // invalid ID instruction never stalls
        clear();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        comb("invalid.no_stall", 1'b0, 1'b0, 1'b0);
        tick();
        regs("invalid.no_stall", 2'b00, 2'b00, 2'b00);

        // taken branch coincident with a load-use hazard
        clear();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        comb("br_ldu.detect", 1'b0, 1'b0, 1'b1);
        tick();
        regs("br_ldu.bubble", 2'b00, 2'b00, 2'b10);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        comb("flush.ignore_br", 1'b0, 1'b0, 1'b0);
        tick();
        regs("flush.exit", 2'b00, 2'b00, 2'b00);
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        comb("run.branch_again", 1'b0, 1'b0, 1'b1);
        tick();
        regs("run.branch_again", 2'b00, 2'b00, 2'b10);

        // reset pulsed while stalled
        clear();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        regs("rst_mid.pre", 2'b00, 2'b00, 2'b10);
        rst_n = 1'b0;
        comb("rst_mid.async", 1'b0, 1'b0, 1'b0);
        regs("rst_mid.async", 2'b00, 2'b00, 2'b00);
        #1 rst_n = 1'b1;
        drive(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        comb("rst_mid.first", 1'b0, 1'b0, 1'b0);
        tick();
        regs("rst_mid.first", 2'b00, 2'b00, 2'b00);

        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low (clk, rst_n).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_valid  input  1  a valid instruction is in the ID stage.
REQ-005 id_rs1 / id_rs2  input  5 each  ID-stage source register indices.
REQ-006 id_use_rs1 / id_use_rs2  input  1 each  instruction reads rs1 / rs2.
REQ-007 id_rd  input  5  ID-stage destination index.
REQ-008 id_reg_wr  input  1  ID-stage instruction writes rd.
REQ-009 id_mem_reg  input  1  ID-stage instruction is a load.
REQ-010 ex_branch_taken  input  1  EX stage resolves a taken branch or jump this cycle.
REQ-011 fwd_rs1 / fwd_rs2  output  2 each  EX operand select: 2'b10 EX/MEM result, 2'b01 MEM/WB result, 2'b00 register file.
REQ-012 ex_is_stall  output  2  EX control: 2'b10 bubble (kills dwe, reg_wr, branch), 2'b00 normal.
REQ-013 pc_hold / ifid_hold  output  1 each  freeze PC and IF/ID register.
REQ-014 ifid_flush  output  1  replace IF/ID contents with a NOP.

Function
REQ-015 SHALL keep two shadow slots, EXS and MEMS, each holding {rd[4:0], wr, ld}, mirroring the instructions in EX and MEM.
REQ-016 In RUN with no stall or flush: EXS <= {id_rd, id_reg_wr&id_valid, id_mem_reg&id_valid}; MEMS <= EXS.
REQ-017 When a bubble or flush is inserted: EXS <= all-zero; MEMS <= EXS.
REQ-018 A slot matches source rs when slot.wr=1, slot.rd!=0, slot.rd==rs, and the matching id_use_rsX=1.
REQ-019 fwd_rsX SHALL be registered: next value 2'b10 if EXS matches and EXS.ld=0; else 2'b01 if MEMS matches; else 2'b00. EXS has priority over MEMS.
REQ-020 Load-use: EXS matches with EXS.ld=1 and id_valid=1 -> load-use stall.
REQ-021 FSM states: RUN, LDSTALL, FLUSH.
REQ-022 RUN -> LDSTALL on load-use stall: same cycle pc_hold=1, ifid_hold=1 (combinational); next cycle ex_is_stall=2'b10.
REQ-023 LDSTALL -> RUN after exactly one cycle. The held instruction's forwarding is re-evaluated, so the load now in MEMS yields fwd=2'b01.
REQ-024 RUN or LDSTALL -> FLUSH on ex_branch_taken=1: same cycle ifid_flush=1; next cycle ex_is_stall=2'b10; FLUSH -> RUN after one cycle.
REQ-025 ex_branch_taken and load-use in the same cycle: branch wins; pc_hold=0, ifid_hold=0, no LDSTALL entry.
REQ-026 pc_hold, ifid_hold and ifid_flush SHALL be 0 in FLUSH; ex_branch_taken is ignored in FLUSH (the EX instruction is a bubble).
REQ-027 id_valid=0 SHALL never cause a stall; x0 SHALL never forward or stall.
REQ-028 Latency: every registered output reflects the decision made on the preceding edge; no multi-cycle stalls beyond one bubble per hazard.

Reset
REQ-029 While rst_n=0: state=RUN, EXS=MEMS=0, fwd_rs1=fwd_rs2=2'b00, ex_is_stall=2'b00, and pc_hold=ifid_hold=ifid_flush=0.
REQ-030 Reset asserted mid-stall or mid-flush SHALL abort the stall or flush immediately; the first post-reset cycle is RUN with empty shadows.

Configuration
REQ-031 Macro HAZ_MEM_FWD_EN: when defined, MEM/WB forwarding (2'b01) per REQ-019.
REQ-032 Without HAZ_MEM_FWD_EN: fwd_rsX never equals 2'b01. A MEMS match, or an EXS match with EXS.ld=1, instead triggers a one-cycle stall per REQ-022. A load-use hazard then stalls two cycles total (EXS, then MEMS).

Verification
REQ-033 add x5 then add x6,x5,x1 back-to-back -> fwd_rs1=2'b10 in the consumer's EX cycle, no stall.
REQ-034 add x5; nop; sub x7,x2,x5 -> fwd_rs2=2'b01 (macro on); macro off -> one bubble, ex_is_stall=2'b10 for 1 cycle, then fwd 2'b00.
REQ-035 lw x8; add x9,x8,x8 -> pc_hold=ifid_hold=1 for 1 cycle, ex_is_stall=2'b10 for 1 cycle, then fwd_rs1=fwd_rs2=2'b01.
REQ-036 Writes to x0 followed by a reader of x0 -> fwd=2'b00, no stall.
REQ-037 ex_branch_taken=1 in the same cycle as a load-use hazard -> ifid_flush=1, pc_hold=0, next cycle ex_is_stall=2'b10, then RUN.
REQ-038 rst_n pulsed low during LDSTALL -> all outputs 0 asynchronously; the first instruction after release gets no forwarding.
